// File: rtl/exe_stage_pkg.sv
// rtl/exe_stage_pkg.sv - shared ALU opcodes, divider state codes and pipeline constants
// Purpose: common encodings imported by the execute stage, its divider and the bench.
// Ports: none (package).
package exe_stage_pkg;

  localparam logic [4:0] ALUOP_ADD   = 5'd0;
  localparam logic [4:0] ALUOP_ADDU  = 5'd1;
  localparam logic [4:0] ALUOP_SUB   = 5'd2;
  localparam logic [4:0] ALUOP_SUBU  = 5'd3;
  localparam logic [4:0] ALUOP_AND   = 5'd4;
  localparam logic [4:0] ALUOP_OR    = 5'd5;
  localparam logic [4:0] ALUOP_XOR   = 5'd6;
  localparam logic [4:0] ALUOP_NOR   = 5'd7;
  localparam logic [4:0] ALUOP_SLT   = 5'd8;
  localparam logic [4:0] ALUOP_SLTU  = 5'd9;
  localparam logic [4:0] ALUOP_SLL   = 5'd10;
  localparam logic [4:0] ALUOP_SRL   = 5'd11;
  localparam logic [4:0] ALUOP_SRA   = 5'd12;
  localparam logic [4:0] ALUOP_LUI   = 5'd13;
  localparam logic [4:0] ALUOP_MULT  = 5'd14;
  localparam logic [4:0] ALUOP_MULTU = 5'd15;
  localparam logic [4:0] ALUOP_DIV   = 5'd16;
  localparam logic [4:0] ALUOP_DIVU  = 5'd17;
  localparam logic [4:0] ALUOP_MFHI  = 5'd18;
  localparam logic [4:0] ALUOP_MFLO  = 5'd19;
  localparam logic [4:0] ALUOP_MTHI  = 5'd20;
  localparam logic [4:0] ALUOP_MTLO  = 5'd21;

  localparam logic        Stop     = 1'b1;
  localparam logic        NoStop   = 1'b0;
  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/exe_stage_if.sv
// rtl/exe_stage_if.sv - ID/EX operand bundle and EX/MEM result bundle of the execute stage
// Purpose: groups stall/flush, ID/EX inputs and EX/MEM outputs.
// Modports: master = ID/EX + controller side (drives i_*/stall), slave = exe_stage.
// Optional: EXE_OVERFLOW_EXC_EN adds o_ovf.
interface exe_stage_if;
  logic [5:0]  stall;
  logic        i_flush;
  logic [4:0]  i_aluop;
  logic        i_write_mem;
  logic        i_write_regfile;
  logic        i_jal;
  logic        i_aluimm;
  logic        i_shift;
  logic [31:0] i_pc;
  logic [31:0] i_da;
  logic [31:0] i_db;
  logic [31:0] i_imm;
  logic [4:0]  i_rn;
  logic [31:0] o_result;
  logic [31:0] o_store_data;
  logic        o_write_mem;
  logic        o_write_regfile;
  logic [4:0]  o_rn;
  logic        o_stall_req;
  logic [31:0] o_hi;
  logic [31:0] o_lo;
`ifdef EXE_OVERFLOW_EXC_EN
  logic        o_ovf;
`endif

  modport master (
    output stall, i_flush, i_aluop, i_write_mem, i_write_regfile, i_jal, i_aluimm,
           i_shift, i_pc, i_da, i_db, i_imm, i_rn,
    input  o_result, o_store_data, o_write_mem, o_write_regfile, o_rn, o_stall_req,
           o_hi, o_lo
`ifdef EXE_OVERFLOW_EXC_EN
    , input o_ovf
`endif
  );

  modport slave (
    input  stall, i_flush, i_aluop, i_write_mem, i_write_regfile, i_jal, i_aluimm,
           i_shift, i_pc, i_da, i_db, i_imm, i_rn,
    output o_result, o_store_data, o_write_mem, o_write_regfile, o_rn, o_stall_req,
           o_hi, o_lo
`ifdef EXE_OVERFLOW_EXC_EN
    , output o_ovf
`endif
  );

endinterface

// File: rtl/exe_stage_div_iter.sv
// rtl/exe_stage_div_iter.sv - radix-2 restoring divider with IDLE/BUSY/DONE control
// Purpose: signed/unsigned 32-bit divide, one quotient bit per cycle.
// Ports: clk, reset (sync, active-high); start_i, signed_op_i, dividend_i, divisor_i,
//        cancel_i, ack_i in; busy_o (stall request), done_o, quot_o, rem_o out.
module exe_stage_div_iter
  import exe_stage_pkg::*;
#(
  parameter int DIV_ITERS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic        signed_op_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  input  logic        cancel_i,
  input  logic        ack_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] quot_o,
  output logic [31:0] rem_o
);

  localparam int CW = $clog2(DIV_ITERS);
  localparam logic [CW-1:0] LAST = CW'(DIV_ITERS - 1);

  div_state_t  state_q, state_d;
  logic [31:0] rem_q, rem_d, quot_q, quot_d, dvsr_q, dvsr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        negq_q, negq_d, negr_q, negr_d;
  logic [32:0] shifted, trial;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    dvsr_d  = dvsr_q;
    cnt_d   = cnt_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    busy_o  = NoStop;
    done_o  = 1'b0;
    // quot_q doubles as the dividend shift register while BUSY
    shifted = {rem_q, quot_q[31]};
    trial   = shifted - {1'b0, dvsr_q};
    case (state_q)
      DIV_IDLE: begin
        if (start_i) begin
          busy_o = Stop;
          if (divisor_i == ZeroWord) begin
            // divide by zero: fixed result, no sign fix-up afterwards
            quot_d  = 32'hFFFF_FFFF;
            rem_d   = dividend_i;
            negq_d  = 1'b0;
            negr_d  = 1'b0;
            state_d = DIV_DONE;
          end else begin
            quot_d  = (signed_op_i && dividend_i[31]) ? (ZeroWord - dividend_i) : dividend_i;
            dvsr_d  = (signed_op_i && divisor_i[31]) ? (ZeroWord - divisor_i) : divisor_i;
            rem_d   = ZeroWord;
            negq_d  = signed_op_i && (dividend_i[31] ^ divisor_i[31]);
            negr_d  = signed_op_i && dividend_i[31];
            cnt_d   = '0;
            state_d = DIV_BUSY;
          end
        end
      end
      DIV_BUSY: begin
        busy_o = Stop;
        if (!trial[32]) begin
          rem_d  = trial[31:0];
          quot_d = {quot_q[30:0], 1'b1};
        end else begin
          rem_d  = shifted[31:0];
          quot_d = {quot_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = DIV_DONE;
      end
      DIV_DONE: begin
        done_o = 1'b1;
        // result is held here until the stage is allowed to advance
        if (ack_i) state_d = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase
    if (cancel_i) state_d = DIV_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= DIV_IDLE;
      rem_q   <= ZeroWord;
      quot_q  <= ZeroWord;
      dvsr_q  <= ZeroWord;
      cnt_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      dvsr_q  <= dvsr_d;
      cnt_q   <= cnt_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
    end
  end

  assign quot_o = negq_q ? (ZeroWord - quot_q) : quot_q;
  assign rem_o  = negr_q ? (ZeroWord - rem_q) : rem_q;

endmodule

// File: rtl/exe_stage.sv
// rtl/exe_stage.sv - MIPS execute stage: ALU, jal link, HI/LO registers, iterative divide
// Purpose: computes the EX result, owns HI/LO, requests stalls while a divide runs.
// Ports: clk, reset (sync, active-high); bus (exe_stage_if.slave): stall, i_flush and
//        ID/EX controls/operands in; o_result, o_store_data, o_write_mem,
//        o_write_regfile, o_rn, o_stall_req, o_hi, o_lo out.
// Optional: EXE_OVERFLOW_EXC_EN adds o_ovf and suppresses the regfile write on
//           signed ADD/SUB overflow.
module exe_stage
  import exe_stage_pkg::*;
#(
  parameter int DIV_ITERS = 32
) (
  input  logic       clk,
  input  logic       reset,
  exe_stage_if.slave bus
);

  logic [31:0] op_b, sum, diff, alu_res;
  logic [4:0]  shamt;
  logic [63:0] prod_s, prod_u;
  logic        advance, is_div, div_busy, div_done;
  logic [31:0] div_quot, div_rem;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        unused_stall;

  assign unused_stall = &{1'b0, bus.stall[5:3], bus.stall[1:0]};

  assign op_b   = bus.i_aluimm ? bus.i_imm : bus.i_db;
  assign shamt  = bus.i_shift ? bus.i_imm[10:6] : bus.i_da[4:0];
  assign sum    = bus.i_da + op_b;
  assign diff   = bus.i_da - op_b;
  assign prod_s = $signed({{32{bus.i_da[31]}}, bus.i_da}) * $signed({{32{op_b[31]}}, op_b});
  assign prod_u = {32'h0, bus.i_da} * {32'h0, op_b};

  assign advance = !bus.stall[2] && !bus.i_flush;
  assign is_div  = (bus.i_aluop == ALUOP_DIV) || (bus.i_aluop == ALUOP_DIVU);

  always_comb begin
    alu_res = ZeroWord;
    case (bus.i_aluop)
      ALUOP_ADD, ALUOP_ADDU: alu_res = sum;
      ALUOP_SUB, ALUOP_SUBU: alu_res = diff;
      ALUOP_AND:  alu_res = bus.i_da & op_b;
      ALUOP_OR:   alu_res = bus.i_da | op_b;
      ALUOP_XOR:  alu_res = bus.i_da ^ op_b;
      ALUOP_NOR:  alu_res = ~(bus.i_da | op_b);
      ALUOP_SLT:  alu_res = {31'h0, $signed(bus.i_da) < $signed(op_b)};
      ALUOP_SLTU: alu_res = {31'h0, bus.i_da < op_b};
      ALUOP_SLL:  alu_res = op_b << shamt;
      ALUOP_SRL:  alu_res = op_b >> shamt;
      ALUOP_SRA:  alu_res = $unsigned($signed(op_b) >>> shamt);
      ALUOP_LUI:  alu_res = {op_b[15:0], 16'h0};
      ALUOP_MFHI: alu_res = hi_q;
      ALUOP_MFLO: alu_res = lo_q;
      default:    alu_res = ZeroWord;
    endcase
  end

  exe_stage_div_iter #(.DIV_ITERS(DIV_ITERS)) u_div (
    .clk        (clk),
    .reset      (reset),
    .start_i    (is_div && !bus.i_flush && !reset),
    .signed_op_i(bus.i_aluop == ALUOP_DIV),
    .dividend_i (bus.i_da),
    .divisor_i  (op_b),
    .cancel_i   (bus.i_flush),
    .ack_i      (advance),
    .busy_o     (div_busy),
    .done_o     (div_done),
    .quot_o     (div_quot),
    .rem_o      (div_rem)
  );

  // HI/LO commit at the end of EX, so a following MFHI/MFLO reads them directly
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (advance) begin
      case (bus.i_aluop)
        ALUOP_MTHI:  hi_d = bus.i_da;
        ALUOP_MTLO:  lo_d = bus.i_da;
        ALUOP_MULT:  {hi_d, lo_d} = prod_s;
        ALUOP_MULTU: {hi_d, lo_d} = prod_u;
        ALUOP_DIV, ALUOP_DIVU: begin
          if (div_done) begin
            hi_d = div_rem;
            lo_d = div_quot;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= ZeroWord;
      lo_q <= ZeroWord;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign bus.o_result     = bus.i_jal ? (bus.i_pc + 32'd8) : alu_res;
  assign bus.o_store_data = bus.i_db;
  assign bus.o_write_mem  = bus.i_write_mem;
  assign bus.o_rn         = bus.i_rn;
  assign bus.o_stall_req  = div_busy;
  assign bus.o_hi         = hi_q;
  assign bus.o_lo         = lo_q;

`ifdef EXE_OVERFLOW_EXC_EN
  logic ovf;
  assign ovf = ((bus.i_aluop == ALUOP_ADD) && (bus.i_da[31] == op_b[31]) && (sum[31] != bus.i_da[31]))
            || ((bus.i_aluop == ALUOP_SUB) && (bus.i_da[31] != op_b[31]) && (diff[31] != bus.i_da[31]));
  assign bus.o_ovf           = ovf;
  assign bus.o_write_regfile = bus.i_write_regfile && !ovf;
`else
  assign bus.o_write_regfile = bus.i_write_regfile;
`endif

endmodule

// File: tb/tb_exe_stage.sv
// tb/tb_exe_stage.sv - directed table-driven bench for exe_stage
module tb_exe_stage;
  import exe_stage_pkg::*;

  typedef struct {
    logic [4:0]  op;
    logic        aluimm;
    logic        shift;
    logic        jal;
    logic [31:0] pc;
    logic [31:0] da;
    logic [31:0] db;
    logic [31:0] imm;
    logic [31:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  stall_ext;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] m_hi, m_lo;
  vec_t        vecs[15];

  exe_stage_if bus();
  // controller model: EX is held whenever the stage asks for a stall
  assign bus.stall = stall_ext | {3'b000, bus.o_stall_req, 2'b00};

  exe_stage #(.DIV_ITERS(32)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_op(input logic [4:0] op, input logic [31:0] da, input logic [31:0] db);
    bus.i_aluop  = op;
    bus.i_da     = da;
    bus.i_db     = db;
    bus.i_imm    = 32'h0;
    bus.i_aluimm = 1'b0;
    bus.i_shift  = 1'b0;
    bus.i_jal    = 1'b0;
    bus.i_pc     = 32'h0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_div(input string nm, input int exp_cyc);
    int cyc = 0;
    #1;
    while (bus.o_stall_req && cyc < 200) begin
      cyc++;
      step();
    end
    chk({nm, "_stall_cycles"}, 64'(cyc), 64'(exp_cyc));
  endtask

  task automatic run_div(input string nm, input logic [4:0] op, input logic [31:0] da,
                         input logic [31:0] db, input int exp_cyc,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    set_op(op, da, db);
    wait_div(nm, exp_cyc);
    chk({nm, "_hilo_before_commit"}, {bus.o_hi, bus.o_lo}, {m_hi, m_lo});
    step();
    m_hi = exp_hi;
    m_lo = exp_lo;
    chk({nm, "_hilo"}, {bus.o_hi, bus.o_lo}, {m_hi, m_lo});
    set_op(ALUOP_ADDU, 32'h0, 32'h0);
  endtask

  initial begin
    vecs[0]  = '{ALUOP_ADDU, 1'b1, 1'b0, 1'b0, 32'h0,   32'hFFFFFFFF, 32'h0,        32'h1,    32'h0};
    vecs[1]  = '{ALUOP_SRA,  1'b0, 1'b1, 1'b0, 32'h0,   32'h0,        32'h80000000, 32'h100,  32'hF8000000};
    vecs[2]  = '{ALUOP_ADDU, 1'b0, 1'b0, 1'b1, 32'h100, 32'h0,        32'h0,        32'h0,    32'h108};
    vecs[3]  = '{ALUOP_SUBU, 1'b0, 1'b0, 1'b0, 32'h0,   32'h5,        32'h7,        32'h0,    32'hFFFFFFFE};
    vecs[4]  = '{ALUOP_AND,  1'b0, 1'b0, 1'b0, 32'h0,   32'hF0F0F0F0, 32'hFF00FF00, 32'h0,    32'hF000F000};
    vecs[5]  = '{ALUOP_OR,   1'b0, 1'b0, 1'b0, 32'h0,   32'hF0F0F0F0, 32'hFF00FF00, 32'h0,    32'hFFF0FFF0};
    vecs[6]  = '{ALUOP_XOR,  1'b0, 1'b0, 1'b0, 32'h0,   32'hF0F0F0F0, 32'hFF00FF00, 32'h0,    32'h0FF00FF0};
    vecs[7]  = '{ALUOP_NOR,  1'b0, 1'b0, 1'b0, 32'h0,   32'hF0F0F0F0, 32'hFF00FF00, 32'h0,    32'h000F000F};
    vecs[8]  = '{ALUOP_SLT,  1'b0, 1'b0, 1'b0, 32'h0,   32'hFFFFFFFF, 32'h1,        32'h0,    32'h1};
    vecs[9]  = '{ALUOP_SLTU, 1'b0, 1'b0, 1'b0, 32'h0,   32'hFFFFFFFF, 32'h1,        32'h0,    32'h0};
    vecs[10] = '{ALUOP_SLL,  1'b0, 1'b0, 1'b0, 32'h0,   32'h4,        32'hF,        32'h0,    32'hF0};
    vecs[11] = '{ALUOP_SRL,  1'b0, 1'b0, 1'b0, 32'h0,   32'h4,        32'h80000000, 32'h0,    32'h08000000};
    vecs[12] = '{ALUOP_LUI,  1'b1, 1'b0, 1'b0, 32'h0,   32'h0,        32'h0,        32'h1234, 32'h12340000};
    vecs[13] = '{ALUOP_ADD,  1'b0, 1'b0, 1'b0, 32'h0,   32'h3,        32'h4,        32'h0,    32'h7};
    vecs[14] = '{ALUOP_SUB,  1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        32'h1,        32'h0,    32'hFFFFFFFF};

    reset               = 1'b1;
    stall_ext           = 6'h0;
    bus.i_flush         = 1'b0;
    bus.i_write_mem     = 1'b0;
    bus.i_write_regfile = 1'b0;
    bus.i_rn            = 5'h0;
    set_op(ALUOP_ADD, 32'h0, 32'h0);
    repeat (2) step();
    m_hi = 32'h0;
    m_lo = 32'h0;
    chk("reset_hi", bus.o_hi, m_hi);
    chk("reset_lo", bus.o_lo, m_lo);
    chk("reset_stall_req", bus.o_stall_req, 1'b0);
    chk("reset_result", bus.o_result, 32'h0);
    reset = 1'b0;
    bus.i_write_regfile = 1'b1;

    for (int i = 0; i < 15; i++) begin
      bus.i_aluop     = vecs[i].op;
      bus.i_aluimm    = vecs[i].aluimm;
      bus.i_shift     = vecs[i].shift;
      bus.i_jal       = vecs[i].jal;
      bus.i_pc        = vecs[i].pc;
      bus.i_da        = vecs[i].da;
      bus.i_db        = vecs[i].db;
      bus.i_imm       = vecs[i].imm;
      bus.i_rn        = 5'(i + 1);
      bus.i_write_mem = i[0];
      #1;
      chk($sformatf("vec%0d_result", i), bus.o_result, vecs[i].exp);
      chk($sformatf("vec%0d_store_data", i), bus.o_store_data, vecs[i].db);
      chk($sformatf("vec%0d_rn", i), bus.o_rn, 5'(i + 1));
      chk($sformatf("vec%0d_write_mem", i), bus.o_write_mem, i[0]);
      chk($sformatf("vec%0d_write_regfile", i), bus.o_write_regfile, 1'b1);
      chk($sformatf("vec%0d_stall_req", i), bus.o_stall_req, 1'b0);
      step();
    end

    // MULT / MULTU / MTHI / MTLO and immediate read-back
    set_op(ALUOP_MULT, 32'hFFFFFFFE, 32'h3);
    #1;
    chk("mult_stall_req", bus.o_stall_req, 1'b0);
    step();
    m_hi = 32'hFFFFFFFF; m_lo = 32'hFFFFFFFA;
    chk("mult_hilo", {bus.o_hi, bus.o_lo}, {m_hi, m_lo});
    set_op(ALUOP_MFHI, 32'h0, 32'h0);
    #1;
    chk("mfhi_after_mult", bus.o_result, m_hi);
    set_op(ALUOP_MULTU, 32'hFFFFFFFE, 32'h3);
    step();
    m_hi = 32'h2; m_lo = 32'hFFFFFFFA;
    chk("multu_hilo", {bus.o_hi, bus.o_lo}, {m_hi, m_lo});
    set_op(ALUOP_MTHI, 32'h55, 32'h0);
    step();
    set_op(ALUOP_MTLO, 32'hAA, 32'h0);
    step();
    m_hi = 32'h55; m_lo = 32'hAA;
    chk("mthi_mtlo", {bus.o_hi, bus.o_lo}, {m_hi, m_lo});

    // divides
    run_div("div_m7_2", ALUOP_DIV, 32'hFFFFFFF9, 32'h2, 33, 32'hFFFFFFFF, 32'hFFFFFFFD);
    set_op(ALUOP_MFLO, 32'h0, 32'h0);
    #1;
    chk("mflo_after_div", bus.o_result, 32'hFFFFFFFD);
    run_div("div_7_m2", ALUOP_DIV, 32'h7, 32'hFFFFFFFE, 33, 32'h1, 32'hFFFFFFFD);
    run_div("divu_by_zero", ALUOP_DIVU, 32'h1234, 32'h0, 1, 32'h1234, 32'hFFFFFFFF);

    // flush while BUSY
    set_op(ALUOP_DIVU, 32'd100, 32'd7);
    repeat (5) step();
    chk("flush_busy_stall_req", bus.o_stall_req, 1'b1);
    bus.i_flush = 1'b1;
    step();
    chk("flush_stall_req_drop", bus.o_stall_req, 1'b0);
    bus.i_flush = 1'b0;
    set_op(ALUOP_ADDU, 32'h0, 32'h0);
    repeat (2) step();
    chk("flush_hilo_kept", {bus.o_hi, bus.o_lo}, {m_hi, m_lo});

    // DONE held by a downstream stall
    set_op(ALUOP_DIVU, 32'd100, 32'd7);
    wait_div("hold", 33);
    stall_ext = 6'b001100;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("hold%0d_hilo", k), {bus.o_hi, bus.o_lo}, {m_hi, m_lo});
      chk($sformatf("hold%0d_stall_req", k), bus.o_stall_req, 1'b0);
    end
    stall_ext = 6'h0;
    step();
    m_hi = 32'd2; m_lo = 32'd14;
    chk("hold_release_hilo", {bus.o_hi, bus.o_lo}, {m_hi, m_lo});
    set_op(ALUOP_ADDU, 32'h0, 32'h0);

    // reset while BUSY
    set_op(ALUOP_DIVU, 32'd100, 32'd7);
    repeat (3) step();
    chk("rst_busy_stall_req", bus.o_stall_req, 1'b1);
    reset = 1'b1;
    step();
    m_hi = 32'h0; m_lo = 32'h0;
    chk("rst_busy_hilo", {bus.o_hi, bus.o_lo}, {m_hi, m_lo});
    chk("rst_busy_stall_req_low", bus.o_stall_req, 1'b0);
    set_op(ALUOP_ADDU, 32'h0, 32'h0);
    reset = 1'b0;
    step();
    chk("rst_after_idle", bus.o_stall_req, 1'b0);

    // signed overflow handling
    set_op(ALUOP_ADD, 32'h7FFFFFFF, 32'h1);
    #1;
`ifdef EXE_OVERFLOW_EXC_EN
    chk("ovf_add_flag", bus.o_ovf, 1'b1);
    chk("ovf_add_wr", bus.o_write_regfile, 1'b0);
    bus.i_db = 32'h0; bus.i_imm = 32'h1; bus.i_aluimm = 1'b1;
    #1;
    chk("ovf_addi_flag", bus.o_ovf, 1'b1);
    set_op(ALUOP_ADD, 32'h3, 32'h4);
    #1;
    chk("no_ovf_flag", bus.o_ovf, 1'b0);
    chk("no_ovf_wr", bus.o_write_regfile, 1'b1);
`else
    chk("wrap_add_result", bus.o_result, 32'h80000000);
    chk("wrap_add_wr", bus.o_write_regfile, 1'b1);
`endif
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
